axi4lite_multich_loader: RTL and testbench

- Parametrised AXI4-Lite slave that fronts the CNN accelerator.
- Demultiplexes host word writes into up to 4 load channels (weights, bias, fmap, spare) as valid/ready streams.
- Provides control (run, soft reset, irq enable), per-channel word counters, overflow detection, result capture and a done interrupt.
- Successor to the fixed-map loader: channel count and depths are parameters, and it adds backpressure, bounded counts, error response and an interrupt.

---
 rtl/axi4lite_multich_loader_if.sv | 52 +++++
 rtl/axi4lite_multich_loader.sv | 223 ++++++++++++++++++++++
 tb/tb_axi4lite_multich_loader.sv | 285 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/axi4lite_multich_loader_if.sv
// AXI4-Lite bus bundle for the multi-channel loader.
// The slave modport faces the loader; the master modport faces the host.
interface axi4lite_multich_loader_if #(
  parameter int unsigned ADDR_W = 6,
  parameter int unsigned DATA_W = 32
);
  logic [ADDR_W-1:0]   awaddr;
  logic [2:0]          awprot;
  logic                awvalid;
  logic                awready;
  logic [DATA_W-1:0]   wdata;
  logic [DATA_W/8-1:0] wstrb;
  logic                wvalid;
  logic                wready;
  logic [1:0]          bresp;
  logic                bvalid;
  logic                bready;
  logic [ADDR_W-1:0]   araddr;
  logic [2:0]          arprot;
  logic                arvalid;
  logic                arready;
  logic [DATA_W-1:0]   rdata;
  logic [1:0]          rresp;
  logic                rvalid;
  logic                rready;

  modport slave (
    input  awaddr, awprot, awvalid,
    output awready,
    input  wdata, wstrb, wvalid,
    output wready,
    output bresp, bvalid,
    input  bready,
    input  araddr, arprot, arvalid,
    output arready,
    output rdata, rresp, rvalid,
    input  rready
  );

  modport master (
    output awaddr, awprot, awvalid,
    input  awready,
    output wdata, wstrb, wvalid,
    input  wready,
    input  bresp, bvalid,
    output bready,
    output araddr, arprot, arvalid,
    input  arready,
    input  rdata, rresp, rvalid,
    output rready
  );
endinterface

// File: rtl/axi4lite_multich_loader.sv
// AXI4-Lite slave that demultiplexes host word writes into per-channel load
// streams and exposes control, counters, status and the done interrupt.
module axi4lite_multich_loader #(
  parameter int unsigned C_S_AXI_DATA_WIDTH = 32,
  parameter int unsigned C_S_AXI_ADDR_WIDTH = 6,
  parameter int unsigned NUM_CH             = 3,
  parameter int unsigned CNT_W              = 16,
  parameter logic [NUM_CH*CNT_W-1:0] CH_DEPTH = {16'd3220, 16'd10, 16'd784},
  parameter int unsigned RESULT_W           = 4
) (
  input  logic                          ACLK,
  input  logic                          ARESETN,
  axi4lite_multich_loader_if.slave      s_axi,
  output logic [NUM_CH-1:0]             ld_valid,
  output logic [C_S_AXI_DATA_WIDTH-1:0] ld_data,
  input  logic [NUM_CH-1:0]             ld_ready,
  output logic                          acc_start,
  output logic                          acc_soft_rst,
  input  logic                          acc_done,
  input  logic [RESULT_W-1:0]           acc_result,
  output logic                          all_loaded,
  output logic                          irq
);

  localparam int unsigned DW = C_S_AXI_DATA_WIDTH;
  localparam int unsigned AW = C_S_AXI_ADDR_WIDTH;
  localparam int unsigned SW = DW / 8;

  typedef enum logic [1:0] {W_IDLE, W_DECODE, W_PUSH, W_RESP} wstate_t;

  wstate_t           state, state_n;
  logic [AW-1:0]     addr_q;
  logic [DW-1:0]     data_q;
  logic [SW-1:0]     strb_q;
  logic [1:0]        bresp_q;
  logic              ctrl_start, irq_en, soft_rst, done, overflow;
  logic [RESULT_W-1:0] result_q;
  logic [CNT_W-1:0]  cnt [NUM_CH];
  logic [NUM_CH-1:0] full;
  logic              rvalid_q;
  logic [DW-1:0]     rdata_q;

  int unsigned       widx;
  logic              is_ch, tgt_full;
  logic [NUM_CH-1:0] dec_sel;
  logic              aw_hs, bvalid_c, push_fire, reg_wr, ovf_hit, clear_wr;
  logic [NUM_CH-1:0] ld_valid_c;
  logic              ar_hs;
  logic [DW-1:0]     rd_mux, status;

  // Channel fill state and the write-target decode of the captured address
  always_comb begin
    full = '0;
    for (int unsigned k = 0; k < NUM_CH; k++)
      full[k] = (cnt[k] == CH_DEPTH[k*CNT_W +: CNT_W]);
  end

  always_comb begin
    widx     = 32'(addr_q[AW-1:2]);
    is_ch    = (widx >= 1) && (widx <= NUM_CH);
    dec_sel  = is_ch ? (NUM_CH'(1) << (widx - 1)) : '0;
    tgt_full = |(dec_sel & full);
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) state <= W_IDLE;
    else          state <= state_n;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      W_IDLE:   if (aw_hs)          state_n = W_DECODE;
      W_DECODE: state_n = (is_ch && !tgt_full) ? W_PUSH : W_RESP;
      W_PUSH:   if (push_fire)      state_n = W_RESP;
      W_RESP:   if (s_axi.bready)   state_n = W_IDLE;
      default:  state_n = W_IDLE;
    endcase
  end

  always_comb begin
    aw_hs      = (state == W_IDLE) && s_axi.awvalid && s_axi.wvalid;
    bvalid_c   = (state == W_RESP);
    ld_valid_c = (state == W_PUSH) ? dec_sel : '0;
    push_fire  = |(ld_valid_c & ld_ready);
    reg_wr     = (state == W_DECODE) && !is_ch;
    ovf_hit    = (state == W_DECODE) && is_ch && tgt_full;
    clear_wr   = reg_wr && (widx == 0) && strb_q[0] && ctrl_start && !data_q[0];
  end

  assign s_axi.awready = aw_hs;
  assign s_axi.wready  = aw_hs;
  assign s_axi.bvalid  = bvalid_c;
  assign s_axi.bresp   = bresp_q;
  assign ld_valid      = ld_valid_c;
  assign ld_data       = data_q;

  // addr_q/data_q only move in W_IDLE, so they also hold the stream word stable
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      addr_q  <= '0;
      data_q  <= '0;
      strb_q  <= '0;
      bresp_q <= '0;
    end else begin
      if (aw_hs) begin
        addr_q <= s_axi.awaddr;
        data_q <= s_axi.wdata;
        strb_q <= s_axi.wstrb;
      end
      if (state == W_DECODE)
        bresp_q <= ovf_hit ? 2'b10 : 2'b00;
    end
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      ctrl_start <= 1'b0;
      irq_en     <= 1'b0;
      soft_rst   <= 1'b0;
    end else begin
      if (reg_wr && (widx == 0) && strb_q[0]) begin
        ctrl_start <= data_q[0];
        irq_en     <= data_q[1];
      end
      if (reg_wr && (widx == 7) && strb_q[0])
        soft_rst <= data_q[0];
      if (soft_rst)
        ctrl_start <= 1'b0;
    end
  end

  // A done pulse beats a coincident clearing CTRL write; soft reset beats both
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      done     <= 1'b0;
      result_q <= '0;
      overflow <= 1'b0;
    end else begin
      if (soft_rst) begin
        done     <= 1'b0;
        result_q <= '0;
      end else if (acc_done) begin
        done     <= 1'b1;
        result_q <= acc_result;
      end else if (clear_wr) begin
        done     <= 1'b0;
        result_q <= '0;
      end
      if (soft_rst)     overflow <= 1'b0;
      else if (ovf_hit) overflow <= 1'b1;
    end
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      for (int unsigned k = 0; k < NUM_CH; k++) cnt[k] <= '0;
    end else begin
      for (int unsigned k = 0; k < NUM_CH; k++) begin
        if (soft_rst)
          cnt[k] <= '0;
        else if (push_fire && ld_valid_c[k])
          cnt[k] <= cnt[k] + CNT_W'(1);
      end
    end
  end

  always_comb begin
    status    = '0;
    status[0] = done;
    status[1] = &full;
    status[2] = overflow;
    for (int unsigned k = 0; k < NUM_CH; k++)
      status[4+k] = full[k];
  end

  always_comb begin
    int unsigned ridx;
    ridx   = 32'(s_axi.araddr[AW-1:2]);
    rd_mux = '0;
    case (ridx)
      0: begin
        rd_mux[0] = ctrl_start;
        rd_mux[1] = irq_en;
      end
      5:       rd_mux    = status;
      6:       rd_mux    = DW'(result_q);
      7:       rd_mux[0] = soft_rst;
      default: begin
        for (int unsigned k = 0; k < NUM_CH; k++)
          if (ridx == 8 + k) rd_mux = DW'(cnt[k]);
      end
    endcase
  end

  assign ar_hs = s_axi.arvalid && !rvalid_q;

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
    end else if (ar_hs) begin
      rvalid_q <= 1'b1;
      rdata_q  <= rd_mux;
    end else if (rvalid_q && s_axi.rready) begin
      rvalid_q <= 1'b0;
    end
  end

  assign s_axi.arready = ar_hs;
  assign s_axi.rvalid  = rvalid_q;
  assign s_axi.rdata   = rdata_q;
  assign s_axi.rresp   = 2'b00;

  assign acc_start    = ctrl_start;
  assign acc_soft_rst = soft_rst;
  assign all_loaded   = &full;
  assign irq          = done & irq_en;

  logic unused;
  assign unused = ^{s_axi.awprot, s_axi.arprot, s_axi.araddr[1:0], addr_q[1:0], strb_q[SW-1:1]};

endmodule

// File: tb/tb_axi4lite_multich_loader.sv
// Directed bench for the multi-channel AXI4-Lite loader.
module tb_axi4lite_multich_loader;

  localparam int LIM = 200;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [2:0]  ld_valid;
  logic [31:0] ld_data;
  logic [2:0]  ld_ready = 3'b111;
  logic        acc_start, acc_soft_rst, all_loaded, irq;
  logic        acc_done = 1'b0;
  logic [3:0]  acc_result = '0;

  int checks = 0;
  int failures = 0;
  int hs [3] = '{0, 0, 0};
  int vld1_cycles = 0;
  int last_b_wait = 0;
  logic srst_at_b;

  always #5 clk = ~clk;

  axi4lite_multich_loader_if #(.ADDR_W(6), .DATA_W(32)) bus ();

  axi4lite_multich_loader #(
    .C_S_AXI_DATA_WIDTH(32),
    .C_S_AXI_ADDR_WIDTH(6),
    .NUM_CH(3),
    .CNT_W(16),
    .CH_DEPTH({16'd3220, 16'd10, 16'd784}),
    .RESULT_W(4)
  ) dut (
    .ACLK(clk),
    .ARESETN(rst_n),
    .s_axi(bus),
    .ld_valid(ld_valid),
    .ld_data(ld_data),
    .ld_ready(ld_ready),
    .acc_start(acc_start),
    .acc_soft_rst(acc_soft_rst),
    .acc_done(acc_done),
    .acc_result(acc_result),
    .all_loaded(all_loaded),
    .irq(irq)
  );

  always @(posedge clk) begin
    if (rst_n) begin
      for (int k = 0; k < 3; k++)
        if (ld_valid[k] && ld_ready[k]) hs[k] = hs[k] + 1;
      if (ld_valid[1]) vld1_cycles = vld1_cycles + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic timeout(input string tag);
    checks++;
    failures++;
    $error("FAIL %s observed=timeout expected=handshake", tag);
  endtask

  task automatic axi_aw(input logic [5:0] a, input logic [31:0] d, input logic [3:0] s);
    int n;
    @(negedge clk);
    bus.awaddr = a; bus.wdata = d; bus.wstrb = s;
    bus.awvalid = 1'b1; bus.wvalid = 1'b1;
    #1;
    n = 0;
    while (!(bus.awready && bus.wready) && n < LIM) begin
      @(negedge clk); #1; n++;
    end
    if (n >= LIM) timeout("aw_handshake");
    @(negedge clk);
    bus.awvalid = 1'b0; bus.wvalid = 1'b0;
  endtask

  task automatic axi_b(output logic [1:0] resp);
    int n;
    n = 0;
    while (!bus.bvalid && n < LIM) begin
      @(negedge clk); n++;
    end
    if (n >= LIM) timeout("b_handshake");
    last_b_wait = n;
    resp = bus.bresp;
    srst_at_b = acc_soft_rst;
    bus.bready = 1'b1;
    @(negedge clk);
    bus.bready = 1'b0;
  endtask

  task automatic axi_write(input logic [5:0] a, input logic [31:0] d, input logic [3:0] s,
                           output logic [1:0] resp);
    axi_aw(a, d, s);
    axi_b(resp);
  endtask

  task automatic axi_read(input logic [5:0] a, output logic [31:0] d);
    int n;
    @(negedge clk);
    bus.araddr = a; bus.arvalid = 1'b1;
    #1;
    n = 0;
    while (!bus.arready && n < LIM) begin
      @(negedge clk); #1; n++;
    end
    if (n >= LIM) timeout("ar_handshake");
    @(negedge clk);
    bus.arvalid = 1'b0;
    n = 0;
    while (!bus.rvalid && n < LIM) begin
      @(negedge clk); n++;
    end
    if (n >= LIM) timeout("r_handshake");
    d = bus.rdata;
    bus.rready = 1'b1;
    @(negedge clk);
    bus.rready = 1'b0;
  endtask

  initial begin
    logic [1:0]  resp;
    logic [31:0] rd;
    int bad, base1, vbase;

    bus.awaddr = '0; bus.awprot = '0; bus.awvalid = 1'b0;
    bus.wdata = '0; bus.wstrb = '0; bus.wvalid = 1'b0; bus.bready = 1'b0;
    bus.araddr = '0; bus.arprot = '0; bus.arvalid = 1'b0; bus.rready = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_ld_valid", 32'(ld_valid), 32'h0);
    check("rst_bvalid", 32'(bus.bvalid), 32'h0);
    check("rst_rvalid", 32'(bus.rvalid), 32'h0);
    check("rst_outputs", {28'h0, acc_start, acc_soft_rst, all_loaded, irq}, 32'h0);
    rst_n = 1'b1;
    axi_read(6'h14, rd);  check("rst_status", rd, 32'h0);

    // Async reset in the middle of a stalled push
    ld_ready = 3'b000;
    axi_aw(6'h04, 32'h1234_5678, 4'hF);
    @(negedge clk);
    check("stall_ld_valid", 32'(ld_valid), 32'h1);
    #2 rst_n = 1'b0;
    #1;
    check("arst_ld_valid", 32'(ld_valid), 32'h0);
    check("arst_bvalid", 32'(bus.bvalid), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    ld_ready = 3'b111;
    axi_read(6'h20, rd);  check("arst_cnt0", rd, 32'h0);
    axi_read(6'h14, rd);  check("arst_status", rd, 32'h0);

    // Latencies: push with ready high, then a register write
    axi_write(6'h04, 32'hA5A5_0000, 4'hF, resp);
    check("push_latency", 32'(last_b_wait), 32'd2);
    axi_write(6'h00, 32'h0, 4'hF, resp);
    check("reg_latency", 32'(last_b_wait), 32'd1);

    // Bulk load ch0 (783 more), ch1 first 9
    bad = 0;
    for (int i = 1; i < 784; i++) begin
      axi_write(6'h04, 32'(i), 4'hF, resp);
      if (resp !== 2'b00) bad++;
    end
    for (int i = 0; i < 9; i++) begin
      axi_write(6'h08, 32'h100 + 32'(i), 4'hF, resp);
      if (resp !== 2'b00) bad++;
    end

    // Backpressure on the 10th ch1 word
    ld_ready = 3'b101;
    axi_aw(6'h08, 32'hCAFE_F00D, 4'hF);
    @(negedge clk);
    bad = bad;
    begin
      int unstable;
      unstable = 0;
      for (int i = 0; i < 20; i++) begin
        if (ld_valid !== 3'b010 || ld_data !== 32'hCAFE_F00D || bus.bvalid !== 1'b0) unstable++;
        @(negedge clk);
      end
      check("bp_stable", 32'(unstable), 32'd0);
    end
    check("bp_cnt_hold", 32'(hs[1]), 32'd9);
    ld_ready = 3'b111;
    axi_b(resp);
    check("bp_bresp", 32'(resp), 32'h0);
    axi_read(6'h24, rd);  check("bp_cnt1", rd, 32'd10);
    axi_read(6'h14, rd);  check("status_ch01_full", rd, 32'h30);
    check("all_loaded_partial", 32'(all_loaded), 32'h0);

    for (int i = 0; i < 3220; i++) begin
      axi_write(6'h0C, 32'hC000_0000 + 32'(i), 4'hF, resp);
      if (resp !== 2'b00) bad++;
    end
    check("load_bresp_errors", 32'(bad), 32'd0);
    axi_read(6'h20, rd);  check("load_cnt0", rd, 32'd784);
    axi_read(6'h24, rd);  check("load_cnt1", rd, 32'd10);
    axi_read(6'h28, rd);  check("load_cnt2", rd, 32'd3220);
    axi_read(6'h14, rd);  check("load_status", rd, 32'h72);
    check("load_all_loaded", 32'(all_loaded), 32'h1);
    check("hs_ch0", 32'(hs[0]), 32'd784);
    check("hs_ch2", 32'(hs[2]), 32'd3220);

    // Overflow on the 11th ch1 word
    base1 = hs[1];
    vbase = vld1_cycles;
    axi_write(6'h08, 32'hDEAD_BEEF, 4'hF, resp);
    check("ovf_bresp", 32'(resp), 32'h2);
    check("ovf_no_valid", 32'(vld1_cycles - vbase), 32'd0);
    check("ovf_no_hs", 32'(hs[1] - base1), 32'd0);
    axi_read(6'h24, rd);  check("ovf_cnt1", rd, 32'd10);
    axi_read(6'h14, rd);  check("ovf_status", rd, 32'h76);

    // Unmapped and write-only addresses
    axi_write(6'h3C, 32'hFFFF_FFFF, 4'hF, resp);
    check("unmapped_bresp", 32'(resp), 32'h0);
    axi_read(6'h3C, rd);  check("unmapped_read", rd, 32'h0);
    axi_read(6'h04, rd);  check("ch0_read", rd, 32'h0);

    // Strobes gate register writes
    axi_write(6'h00, 32'h3, 4'h0, resp);
    axi_read(6'h00, rd);  check("ctrl_nostrb", rd, 32'h0);

    // Done / result / irq
    axi_write(6'h00, 32'h3, 4'hF, resp);
    check("acc_start_set", 32'(acc_start), 32'h1);
    @(negedge clk); acc_done = 1'b1; acc_result = 4'd7;
    @(negedge clk); acc_done = 1'b0; acc_result = 4'd0;
    axi_read(6'h18, rd);  check("result_7", rd, 32'd7);
    axi_read(6'h14, rd);  check("done_status", rd, 32'h77);
    check("irq_set", 32'(irq), 32'h1);
    axi_write(6'h00, 32'h2, 4'hF, resp);
    axi_read(6'h14, rd);  check("done_cleared", rd, 32'h76);
    axi_read(6'h18, rd);  check("result_cleared", rd, 32'h0);
    check("irq_cleared", 32'(irq), 32'h0);

    // acc_done coincident with the clearing write: done stays set
    axi_write(6'h00, 32'h3, 4'hF, resp);
    axi_aw(6'h00, 32'h2, 4'hF);
    acc_done = 1'b1; acc_result = 4'd5;
    @(negedge clk); acc_done = 1'b0; acc_result = 4'd0;
    axi_b(resp);
    axi_read(6'h14, rd);  check("done_wins", rd, 32'h77);
    axi_read(6'h18, rd);  check("done_wins_result", rd, 32'd5);
    check("done_wins_start", 32'(acc_start), 32'h0);

    // Soft reset
    check("srst_before", 32'(acc_soft_rst), 32'h0);
    axi_write(6'h1C, 32'h1, 4'hF, resp);
    check("srst_at_first_b", 32'(srst_at_b), 32'h1);
    axi_read(6'h1C, rd);  check("srst_reg", rd, 32'h1);
    axi_read(6'h14, rd);  check("srst_status_held", rd, 32'h0);
    check("srst_held", 32'(acc_soft_rst), 32'h1);
    axi_write(6'h1C, 32'h0, 4'hF, resp);
    check("srst_at_second_b", 32'(srst_at_b), 32'h0);
    axi_read(6'h20, rd);  check("srst_cnt0", rd, 32'h0);
    axi_read(6'h24, rd);  check("srst_cnt1", rd, 32'h0);
    axi_read(6'h28, rd);  check("srst_cnt2", rd, 32'h0);
    axi_read(6'h14, rd);  check("srst_status", rd, 32'h0);
    axi_read(6'h18, rd);  check("srst_result", rd, 32'h0);
    check("srst_irq", 32'(irq), 32'h0);
    axi_write(6'h04, 32'h55, 4'hF, resp);
    axi_read(6'h20, rd);  check("post_srst_push", rd, 32'h1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #3_000_000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "simulation time limit");
  end

endmodule
